// File: rtl/adc_scan_sched.sv
// adc_scan_sched: periodic / software scan scheduler for an 8-channel ADC.
// Averages 2^n scans per channel into a registered 12-bit result buffer.
module adc_scan_sched #(
  parameter int TMO_W = 8
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        cfg_en,
  input  logic [15:0] cfg_period,
  input  logic [1:0]  cfg_avg,
  input  logic        sw_trig,
  input  logic        clr_err,
  output logic        adc_sync,
  input  logic        adc_busy,
  input  logic        adc_rd_en,
  input  logic [11:0] adc_data,
  input  logic [2:0]  rd_addr,
  output logic [11:0] rd_data,
  output logic        scan_done,
  output logic        sched_busy,
  output logic        overrun,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE, START, COLLECT, UPDATE
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LAST =
    {{(TMO_W-1){1'b1}}, 1'b0};
  localparam logic [TMO_W-1:0] TMO_ONE =
    {{(TMO_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nx;
  logic [15:0]      per_cnt;
  logic             per_run;
  logic             per_req;
  logic             req;
  logic             start;
  logic             strobe;
  logic             tmo_hit;
  logic             grp_full;
  logic [TMO_W-1:0] tmo;
  logic [2:0]       smp;
  logic [3:0]       scan_cnt;
  logic [3:0]       scan_nx;
  logic [1:0]       avg_l;
  logic [14:0]      acc  [8];
  logic [11:0]      rbuf [8];
  logic [11:0]      res  [8];

  assign per_run    = cfg_en && (cfg_period != 16'd0);
  assign per_req    = per_run &&
                      (per_cnt >= cfg_period - 16'd1);
  assign req        = per_req | sw_trig;
  assign start      = (state == IDLE) && req;
  assign strobe     = (state == COLLECT) && adc_rd_en;
  assign scan_nx    = scan_cnt + 4'd1;
  assign grp_full   = scan_nx == (4'd1 << avg_l);
  assign adc_sync   = (state == START);
  assign sched_busy = (state != IDLE);

  // Free-running period counter, wraps at the terminal count.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)       per_cnt <= 16'd0;
    else if (!per_run) per_cnt <= 16'd0;
    else if (per_req) per_cnt <= 16'd0;
    else              per_cnt <= per_cnt + 16'd1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next-state and start-timeout detection.
  always_comb begin
    state_nx = state;
    tmo_hit  = 1'b0;
    unique case (state)
      IDLE:    if (req) state_nx = START;
      START: begin
        if (adc_busy) begin
          state_nx = COLLECT;
        end else if (tmo == TMO_LAST) begin
          tmo_hit  = 1'b1;
          state_nx = IDLE;
        end
      end
      COLLECT: if (strobe && smp == 3'd7) state_nx = UPDATE;
      UPDATE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Timeout, sample and scan counters plus latched averaging exponent.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      tmo      <= '0;
      smp      <= 3'd0;
      scan_cnt <= 4'd0;
      avg_l    <= 2'd0;
    end else begin
      if (state == START) tmo <= tmo + TMO_ONE;
      else                tmo <= '0;
      if (start)       smp <= 3'd0;
      else if (strobe) smp <= smp + 3'd1;
      if (start && scan_cnt == 4'd0) avg_l <= cfg_avg;
      if (state == UPDATE)
        scan_cnt <= grp_full ? 4'd0 : scan_nx;
    end
  end

  // Averaged result per channel.
  always_comb begin
    for (int k = 0; k < 8; k++)
      res[k] = 12'(acc[k] >> avg_l);
  end

  // Per-channel accumulators, cleared when a group completes.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int k = 0; k < 8; k++) acc[k] <= 15'd0;
    end else if (state == UPDATE && grp_full) begin
      for (int k = 0; k < 8; k++) acc[k] <= 15'd0;
    end else if (strobe) begin
      acc[smp] <= acc[smp] + 15'(adc_data);
    end
  end

  // Result buffer written once per completed group.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int k = 0; k < 8; k++) rbuf[k] <= 12'd0;
    end else if (state == UPDATE && grp_full) begin
      for (int k = 0; k < 8; k++) rbuf[k] <= res[k];
    end
  end

  // Registered read port, done pulse and sticky error flags.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_data   <= 12'd0;
      scan_done <= 1'b0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      rd_data   <= rbuf[rd_addr];
      scan_done <= (state == UPDATE) && grp_full;
      if (req && sched_busy) overrun <= 1'b1;
      else if (clr_err)      overrun <= 1'b0;
      if (tmo_hit)      timeout <= 1'b1;
      else if (clr_err) timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_scan_sched.sv
// tb_adc_scan_sched: directed scenarios with a scoreboard for
// scan_done timing and rd_data results.
module tb_adc_scan_sched;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        cfg_en = 1'b0;
  logic [15:0] cfg_period = 16'd0;
  logic [1:0]  cfg_avg = 2'd0;
  logic        sw_trig = 1'b0;
  logic        clr_err = 1'b0;
  logic        adc_sync;
  logic        adc_busy = 1'b0;
  logic        adc_rd_en = 1'b0;
  logic [11:0] adc_data = 12'd0;
  logic [2:0]  rd_addr = 3'd0;
  logic [11:0] rd_data;
  logic        scan_done;
  logic        sched_busy;
  logic        overrun;
  logic        timeout;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_q[$];
  logic [11:0] rd_q[$];
  logic        rd_chk = 1'b0;
  logic        rd_pend = 1'b0;

  adc_scan_sched #(.TMO_W(8)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .cfg_en     (cfg_en),
    .cfg_period (cfg_period),
    .cfg_avg    (cfg_avg),
    .sw_trig    (sw_trig),
    .clr_err    (clr_err),
    .adc_sync   (adc_sync),
    .adc_busy   (adc_busy),
    .adc_rd_en  (adc_rd_en),
    .adc_data   (adc_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .scan_done  (scan_done),
    .sched_busy (sched_busy),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_pend <= rd_chk;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  // Scoreboard monitor: scan_done timing and read results.
  always @(negedge clk) begin
    int          e;
    logic [11:0] r;
    if (rst_l && scan_done) begin
      if (done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected actual=1 required=0");
      end else begin
        e = done_q.pop_front();
        chk("done_cycle", cyc, e);
      end
    end
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected actual=%0h required=none",
                 rd_data);
      end else begin
        r = rd_q.pop_front();
        chk("rd_data", {20'd0, rd_data}, {20'd0, r});
      end
    end
  end

  function automatic logic [7:0][11:0] fill(
      input logic [11:0] b, input logic [11:0] s);
    logic [7:0][11:0] d;
    for (int k = 0; k < 8; k++) d[k] = b + s * 12'(k);
    return d;
  endfunction

  task automatic wait_sync();
    int n = 0;
    while (!adc_sync && n < 1200) begin
      @(negedge clk);
      n++;
    end
    chk("sync_seen", {31'd0, adc_sync}, 1);
  endtask

  task automatic trig();
    @(negedge clk);
    sw_trig = 1'b1;
    @(negedge clk);
    sw_trig = 1'b0;
    chk("sync_latency", {31'd0, adc_sync}, 1);
  endtask

  // ADC controller model: acknowledge SYNC, then n sample strobes.
  task automatic serve(input logic [7:0][11:0] d,
                       input int n, input bit fin);
    wait_sync();
    adc_busy = 1'b1;
    @(negedge clk);
    chk("sync_drop", {31'd0, adc_sync}, 0);
    for (int k = 0; k < n; k++) begin
      adc_rd_en = 1'b1;
      adc_data  = d[k];
      if (fin && k == 7) done_q.push_back(cyc + 2);
      @(negedge clk);
    end
    adc_rd_en = 1'b0;
    adc_data  = 12'd0;
    adc_busy  = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [11:0] e);
    @(negedge clk);
    rd_addr = a;
    rd_chk  = 1'b1;
    rd_q.push_back(e);
    @(negedge clk);
    rd_chk = 1'b0;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_sync"},    {31'd0, adc_sync},   0);
    chk({tag, "_done"},    {31'd0, scan_done},  0);
    chk({tag, "_busy"},    {31'd0, sched_busy}, 0);
    chk({tag, "_overrun"}, {31'd0, overrun},    0);
    chk({tag, "_timeout"}, {31'd0, timeout},    0);
    chk({tag, "_rd_data"}, {20'd0, rd_data},    0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t1;
    int t2;

    repeat (2) @(negedge clk);
    chk_idle_outs("reset");
    rst_l = 1'b1;
    rd(3'd5, 12'h000);

    // single scan, no averaging
    cfg_avg = 2'd0;
    trig();
    serve(fill(12'h100, 12'h001), 8, 1'b1);
    for (int k = 0; k < 8; k++)
      rd(3'(k), 12'h100 + 12'(k));

    // four-scan average with a mid-group cfg_avg change
    @(negedge clk);
    cfg_avg   = 2'd2;
    adc_rd_en = 1'b1;
    adc_data  = 12'hFFF;
    @(negedge clk);
    adc_rd_en = 1'b0;
    adc_data  = 12'd0;
    trig();
    serve(fill(12'h000, 12'h000), 8, 1'b0);
    @(negedge clk);
    cfg_avg = 2'd0;
    trig();
    serve(fill(12'h004, 12'h000), 8, 1'b0);
    trig();
    serve(fill(12'h008, 12'h000), 8, 1'b0);
    rd(3'd0, 12'h100);
    trig();
    serve(fill(12'h00C, 12'h000), 8, 1'b1);
    for (int k = 0; k < 8; k++)
      rd(3'(k), 12'h006);

    // read in the UPDATE cycle returns the old value
    trig();
    serve(fill(12'h200, 12'h001), 8, 1'b1);
    rd_addr = 3'd3;
    rd_chk  = 1'b1;
    rd_q.push_back(12'h006);
    @(negedge clk);
    rd_q.push_back(12'h203);
    @(negedge clk);
    rd_chk = 1'b0;

    // ADC never acknowledges SYNC
    trig();
    n = 0;
    while (adc_sync && n < 400) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_cycles", n, 255);
    chk("tmo_flag", {31'd0, timeout}, 1);
    chk("tmo_sync", {31'd0, adc_sync}, 0);
    chk("tmo_idle", {31'd0, sched_busy}, 0);
    rd(3'd3, 12'h203);
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("tmo_clear", {31'd0, timeout}, 0);

    // periodic scans and overrun handling
    @(negedge clk);
    cfg_period = 16'd1000;
    cfg_en     = 1'b1;
    wait_sync();
    t1 = cyc;
    serve(fill(12'h300, 12'h001), 8, 1'b1);
    sw_trig = 1'b1;
    @(negedge clk);
    sw_trig = 1'b0;
    chk("ovr_set", {31'd0, overrun}, 1);
    chk("ovr_idle", {31'd0, sched_busy}, 0);
    wait_sync();
    t2 = cyc;
    chk("period", t2 - t1, 1000);
    serve(fill(12'h400, 12'h001), 8, 1'b1);
    sw_trig = 1'b1;
    clr_err = 1'b1;
    @(negedge clk);
    sw_trig = 1'b0;
    clr_err = 1'b0;
    chk("ovr_set_wins", {31'd0, overrun}, 1);
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("ovr_clear", {31'd0, overrun}, 0);
    cfg_en = 1'b0;
    rd(3'd1, 12'h401);

    // reset in the middle of a scan
    trig();
    serve(fill(12'h007, 12'h000), 4, 1'b0);
    rst_l = 1'b0;
    #1;
    chk_idle_outs("abort");
    @(negedge clk);
    rst_l = 1'b1;
    rd(3'd0, 12'h000);
    trig();
    serve(fill(12'h055, 12'h000), 8, 1'b1);
    rd(3'd7, 12'h055);

    repeat (5) @(negedge clk);
    chk("done_q_empty", done_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_scan_sched.md
ADC_SCAN_SCHED -- requirements
Module: adc_scan_sched

Interface
REQ-001 The block SHALL have parameter TMO_W, default 8, the width of the ADC-start timeout counter (timeout = 2^TMO_W-1 clk cycles).
REQ-002 The block SHALL have port clk, input, 1, system clock; all logic on posedge.
REQ-003 The block SHALL have port rst_l, input, 1, reset, asynchronous, active-low.
REQ-004 The block SHALL have port cfg_en, input, 1, enable for periodic scanning.
REQ-005 The block SHALL have port cfg_period, input, 16, scan period in clk cycles; 0 disables periodic triggering.
REQ-006 The block SHALL have port cfg_avg, input, 2, averaging exponent: 2^cfg_avg scans per result (1/2/4/8).
REQ-007 The block SHALL have port sw_trig, input, 1, single-cycle software scan request.
REQ-008 The block SHALL have port clr_err, input, 1, clears the sticky overrun and timeout flags.
REQ-009 The block SHALL have port adc_sync, output, 1, scan start to the 8-channel ADC controller SYNC input.
REQ-010 The block SHALL have ports adc_busy (in, 1), adc_rd_en (in, 1, one-cycle sample strobe) and adc_data (in, 12); these come from the ADC controller.
REQ-011 The block SHALL have port rd_addr, input, 3, result buffer channel select.
REQ-012 The block SHALL have port rd_data, output, 12, registered result for rd_addr.
REQ-013 The block SHALL have ports scan_done (out, 1, one-cycle pulse), sched_busy (out, 1), overrun (out, 1, sticky) and timeout (out, 1, sticky).

Function
REQ-014 Period counter SHALL count 0..cfg_period-1 while cfg_en=1 and cfg_period!=0, raising a one-cycle request at the terminal count and wrapping to 0; when cfg_en=0 it SHALL be held at 0.
REQ-015 A request SHALL be the OR of the periodic request and sw_trig; coincident requests SHALL start exactly one scan.
REQ-016 FSM states SHALL be IDLE, START, COLLECT, UPDATE; sched_busy=1 in every state except IDLE.
REQ-017 IDLE -> START on a request; START drives adc_sync=1 until adc_busy=1 is sampled, then -> COLLECT with adc_sync=0 on the next cycle.
REQ-018 If adc_busy is not seen within 2^TMO_W-1 cycles in START, the block SHALL set timeout, drop adc_sync and return to IDLE with accumulators unchanged.
REQ-019 In COLLECT each adc_rd_en pulse SHALL add adc_data to accumulator acc[k] (15 bits, no overflow possible) where k is an internal sample counter 0..7 cleared on entering START; on the 8th strobe -> UPDATE.
REQ-020 Strobes of adc_rd_en outside COLLECT SHALL be ignored.
REQ-021 UPDATE (one cycle) SHALL increment the scan counter; when it reaches 2^avg_l it SHALL write acc[k]>>avg_l (12 bits) to buffer[k] for all k, clear all acc and the scan counter, and pulse scan_done; otherwise no write. Then -> IDLE.
REQ-022 avg_l SHALL be latched from cfg_avg when a scan starts with scan counter=0; cfg_avg changes mid-group SHALL take effect at the next group.
REQ-023 A request arriving while sched_busy=1 SHALL be dropped and set overrun.
REQ-024 clr_err SHALL clear overrun and timeout; a set event in the same cycle SHALL win.
REQ-025 rd_data SHALL equal buffer[rd_addr] one cycle after rd_addr is presented; a read in the UPDATE write cycle SHALL return the pre-update value.
REQ-026 Latency from request to adc_sync=1 SHALL be 1 cycle; scan_done SHALL rise 2 cycles after the final adc_rd_en strobe of the group.

Reset
REQ-027 On rst_l=0 the block SHALL asynchronously enter IDLE and drive adc_sync=0, scan_done=0, sched_busy=0, overrun=0, timeout=0, rd_data=0, and clear the period counter, sample counter, scan counter, all accumulators and all buffer entries; a scan in progress SHALL be abandoned.

Verification
REQ-028 cfg_avg=0, sw_trig, ADC model returns data 0x100+k for channel k -> adc_sync then scan_done once, rd_data for addr k = 0x100+k.
REQ-029 cfg_avg=2, four sw_trig scans returning 0x000, 0x004, 0x008, 0x00C on every channel -> scan_done only after the 4th, every buffer entry = 0x006.
REQ-030 cfg_en=1, cfg_period=1000, sw_trig asserted during a scan -> overrun=1, one scan per 1000 cycles; clr_err together with a new overrun -> overrun stays 1.
REQ-031 ADC model never asserts adc_busy, TMO_W=8 -> timeout=1 after 255 cycles, adc_sync=0, FSM in IDLE, buffer unchanged.
REQ-032 rst_l pulsed low after the 4th adc_rd_en of a scan -> all outputs at reset values, buffer reads 0, and the next sw_trig completes a normal scan.
REQ-033 Read of addr 3 in the UPDATE cycle -> old value returned, new value returned on the following cycle.
